// File: rtl/recv_timeout_probe.sv
// ---------------------------------------------------------------------------
// recv_timeout_probe
//
// Receive-path support block for the UDP RX buffer.
//
//  * Watchdog timer: counts enabled cycles and emits a registered one-cycle
//    pulse after 2**TIMER_WIDTH of them.
//    - Counting pauses, and keeps its value, while timer_enable is low.
//    - timer_clear restarts the count.
//    - A clear on the terminal-count cycle suppresses that pulse.
//    - The RX parser uses the pulse to return to idle when a frame stalls.
//  * Probe capture buffer: records the parser debug signals.
//    - Once armed, the first trigger writes that cycle's probe word to
//      mem[0].
//    - Each following cycle is then written unconditionally until the
//      buffer is full.
//    - The buffer then freezes until it is re-armed.
//    - Readback is a registered read with one cycle of latency, legal in
//      any state.
//
// Valid/ready: this block has no flow-controlled interfaces.
//  * Probes are sampled every cycle while capturing, with no back-pressure.
//  * Readback is a fixed-latency random-access read with no handshake.
//
// Ports
//  clk            rising-edge clock
//  reset          synchronous, active-low reset
//  timer_clear    restart the watchdog count (active-high)
//  timer_enable   watchdog count enable
//  timer_out      one-cycle timeout pulse
//  probe0..probe7 parser debug signals (tdata, tvalid, tlast, axis tvalid,
//                 parser state, byte counter, 6-byte and 2-byte windows)
//  cap_arm        pulse: arm, or re-arm, the capture
//  cap_trigger    trigger qualifier, honoured only while armed
//  cap_armed      high while waiting for the trigger or filling the buffer
//  cap_done       high once the buffer is full and frozen
//  rd_addr        readback address
//  rd_data        {probe7,probe6,probe5,probe4,probe3,probe2,probe1,probe0}
//  cap_state_dbg  current capture FSM state, for observation
// ---------------------------------------------------------------------------
module recv_timeout_probe #(
    parameter int TIMER_WIDTH = 12,
    parameter int CAP_DEPTH   = 64,
    parameter int CAP_AW      = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              timer_clear,
    input  logic              timer_enable,
    output logic              timer_out,
    input  logic [7:0]        probe0,
    input  logic              probe1,
    input  logic              probe2,
    input  logic              probe3,
    input  logic [2:0]        probe4,
    input  logic [15:0]       probe5,
    input  logic [47:0]       probe6,
    input  logic [15:0]       probe7,
    input  logic              cap_arm,
    input  logic              cap_trigger,
    output logic              cap_armed,
    output logic              cap_done,
    input  logic [CAP_AW-1:0] rd_addr,
    output logic [93:0]       rd_data,
    output logic [1:0]        cap_state_dbg
);

    localparam int PW = 94;

    typedef enum logic [1:0] {
        CAP_IDLE    = 2'd0,
        CAP_ARMED   = 2'd1,
        CAP_CAPTURE = 2'd2,
        CAP_DONE    = 2'd3
    } cap_state_e;

    // ------------------------------------------------------------------
    // Watchdog timer
    // ------------------------------------------------------------------
    logic [TIMER_WIDTH-1:0] counter_q, counter_d;
    logic                   timer_out_q, timer_out_d;

    always_comb begin
        counter_d   = counter_q;
        timer_out_d = 1'b0;
        if (timer_clear) begin
            // Clear has priority, so it also swallows a terminal count.
            counter_d = '0;
        end else if (timer_enable) begin
            if (&counter_q) begin
                counter_d   = '0;
                timer_out_d = 1'b1;
            end else begin
                counter_d = counter_q + TIMER_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            counter_q   <= '0;
            timer_out_q <= 1'b0;
        end else begin
            counter_q   <= counter_d;
            timer_out_q <= timer_out_d;
        end
    end

    assign timer_out = timer_out_q;

    // ------------------------------------------------------------------
    // Capture FSM
    // ------------------------------------------------------------------
    cap_state_e        state_q, state_d;
    logic [CAP_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic              mem_we;
    logic [PW-1:0]     probe_word;

    assign probe_word = {probe7, probe6, probe5, probe4,
                         probe3, probe2, probe1, probe0};

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        mem_we   = 1'b0;
        case (state_q)
            CAP_IDLE: begin
                if (cap_arm) begin
                    state_d  = CAP_ARMED;
                    wr_ptr_d = '0;
                end
            end
            CAP_ARMED: begin
                if (cap_arm) begin
                    // A re-arm takes priority over a coincident trigger.
                    wr_ptr_d = '0;
                end else if (cap_trigger) begin
                    // wr_ptr is 0 here, so the trigger sample lands in mem[0].
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + CAP_AW'(1);
                    state_d  = CAP_CAPTURE;
                end
            end
            CAP_CAPTURE: begin
                // The current sample is always stored.
                // A coincident arm then restarts from ARMED.
                mem_we = 1'b1;
                if (cap_arm) begin
                    state_d  = CAP_ARMED;
                    wr_ptr_d = '0;
                end else if (wr_ptr_q == CAP_AW'(CAP_DEPTH - 1)) begin
                    state_d  = CAP_DONE;
                    wr_ptr_d = '0;
                end else begin
                    wr_ptr_d = wr_ptr_q + CAP_AW'(1);
                end
            end
            CAP_DONE: begin
                if (cap_arm) begin
                    state_d  = CAP_ARMED;
                    wr_ptr_d = '0;
                end
            end
            default: begin
                state_d  = CAP_IDLE;
                wr_ptr_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= CAP_IDLE;
            wr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // The state register drives both flags directly.
    assign cap_armed     = (state_q == CAP_ARMED) || (state_q == CAP_CAPTURE);
    assign cap_done      = (state_q == CAP_DONE);
    assign cap_state_dbg = state_q;

    // ------------------------------------------------------------------
    // Capture memory
    // ------------------------------------------------------------------
    // Contents are not reset.
    // A reset cycle still blocks the write, so an aborted capture does not
    // store a sample on its reset edge.
    logic [PW-1:0] mem [CAP_DEPTH];
    logic [PW-1:0] rd_data_q, rd_data_d;

    always_ff @(posedge clk) begin
        if (mem_we && reset) begin
            mem[wr_ptr_q] <= probe_word;
        end
    end

    // A read of the address being written in the same cycle returns the
    // old contents, because the write lands on the same edge.
    always_comb begin
        rd_data_d = mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: tb/tb_recv_timeout_probe.sv
module tb_recv_timeout_probe;

  localparam int TW = 4;
  localparam int DEPTH = 64;
  localparam int AW = 6;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b0;
  logic timer_clear = 1'b0;
  logic timer_enable = 1'b0;
  logic timer_out;
  logic [7:0] probe0 = '0;
  logic probe1 = 1'b0;
  logic probe2 = 1'b0;
  logic probe3 = 1'b0;
  logic [2:0] probe4 = '0;
  logic [15:0] probe5 = '0;
  logic [47:0] probe6 = '0;
  logic [15:0] probe7 = '0;
  logic cap_arm = 1'b0;
  logic cap_trigger = 1'b0;
  logic cap_armed;
  logic cap_done;
  logic [AW-1:0] rd_addr = '0;
  logic [93:0] rd_data;
  logic [1:0] cap_state_dbg;

  int total = 0;
  int bad = 0;

  recv_timeout_probe #(
    .TIMER_WIDTH(TW),
    .CAP_DEPTH(DEPTH),
    .CAP_AW(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .timer_clear(timer_clear),
    .timer_enable(timer_enable),
    .timer_out(timer_out),
    .probe0(probe0),
    .probe1(probe1),
    .probe2(probe2),
    .probe3(probe3),
    .probe4(probe4),
    .probe5(probe5),
    .probe6(probe6),
    .probe7(probe7),
    .cap_arm(cap_arm),
    .cap_trigger(cap_trigger),
    .cap_armed(cap_armed),
    .cap_done(cap_done),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .cap_state_dbg(cap_state_dbg)
  );

  // advance one edge; outputs are then sampled 1 ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // expected probe word for ramp value v, built field by field
  function automatic logic [93:0] sample(input int v);
    logic [15:0] w;
    logic [7:0]  p0;
    logic [2:0]  p4;
    logic [47:0] p6;
    logic [15:0] p7;
    w  = v[15:0];
    p0 = w[7:0] ^ 8'hA5;
    p4 = w[2:0] ^ 3'b101;
    p6 = {w, w, w} ^ 48'h1234_5678_9abc;
    p7 = ~w;
    return {p7, p6, w, p4, w[2], w[1], w[0], p0};
  endfunction

  task automatic drive_probes(input int v);
    logic [15:0] w;
    w = v[15:0];
    probe0 = w[7:0] ^ 8'hA5;
    probe1 = w[0];
    probe2 = w[1];
    probe3 = w[2];
    probe4 = w[2:0] ^ 3'b101;
    probe5 = w;
    probe6 = {w, w, w} ^ 48'h1234_5678_9abc;
    probe7 = ~w;
  endtask

  initial begin
    // ---------------- reset ----------------
    reset = 1'b0;
    tick();
    tick();
    check("rst_timer_out", 96'(timer_out), 96'(0));
    check("rst_cap_armed", 96'(cap_armed), 96'(0));
    check("rst_cap_done", 96'(cap_done), 96'(0));
    check("rst_rd_data", 96'(rd_data), 96'(0));
    reset = 1'b1;

    // ---------------- timer terminal count ----------------
    timer_enable = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      check($sformatf("tc1_edge%0d", i), 96'(timer_out), 96'(0));
    end
    tick();
    check("tc1_pulse", 96'(timer_out), 96'(1));
    for (int i = 1; i <= 15; i++) begin
      tick();
      check($sformatf("tc2_edge%0d", i), 96'(timer_out), 96'(0));
    end
    tick();
    check("tc2_pulse", 96'(timer_out), 96'(1));
    timer_enable = 1'b0;
    tick();
    check("tc2_after", 96'(timer_out), 96'(0));

    // ---------------- pause: 10 on, 5 off, 6 on ----------------
    timer_enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("pause_on10", 96'(timer_out), 96'(0));
    end
    timer_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("pause_off5", 96'(timer_out), 96'(0));
    end
    timer_enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("pause_on5", 96'(timer_out), 96'(0));
    end
    tick();
    check("pause_pulse", 96'(timer_out), 96'(1));
    timer_enable = 1'b0;
    tick();
    check("pause_after", 96'(timer_out), 96'(0));

    // ---------------- clear on 15th of 16 ----------------
    timer_enable = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      check("clr15_pre", 96'(timer_out), 96'(0));
    end
    timer_clear = 1'b1;
    tick();
    check("clr15_clear", 96'(timer_out), 96'(0));
    timer_clear = 1'b0;
    tick();
    check("clr15_16th", 96'(timer_out), 96'(0));
    // count is now 1; 14 more edges reach all-ones, then clear on terminal count
    for (int i = 0; i < 14; i++) begin
      tick();
      check("clrtc_pre", 96'(timer_out), 96'(0));
    end
    timer_clear = 1'b1;
    tick();
    check("clrtc_no_pulse", 96'(timer_out), 96'(0));
    timer_clear = 1'b0;
    // counter must be 0 now: a full 16 enabled edges to the next pulse
    for (int i = 0; i < 15; i++) begin
      tick();
      check("clrtc_recount", 96'(timer_out), 96'(0));
    end
    tick();
    check("clrtc_pulse", 96'(timer_out), 96'(1));
    timer_enable = 1'b0;
    tick();

    // ---------------- capture ----------------
    cap_arm = 1'b1;
    tick();
    cap_arm = 1'b0;
    check("arm_armed", 96'(cap_armed), 96'(1));
    check("arm_done", 96'(cap_done), 96'(0));
    for (int v = 0; v <= 70; v++) begin
      drive_probes(v);
      cap_trigger = (v == 7);
      tick();
      if (v == 69) begin
        check("cap_v69_armed", 96'(cap_armed), 96'(1));
        check("cap_v69_done", 96'(cap_done), 96'(0));
      end
    end
    cap_trigger = 1'b0;
    check("cap_full_done", 96'(cap_done), 96'(1));
    check("cap_full_armed", 96'(cap_armed), 96'(0));
    // buffer frozen in DONE while probes keep moving
    for (int v = 71; v < 75; v++) begin
      drive_probes(v);
      cap_trigger = 1'b1;
      tick();
    end
    cap_trigger = 1'b0;
    check("done_hold", 96'(cap_done), 96'(1));

    // ---------------- readback ----------------
    rd_addr = 6'd0;
    tick();
    check("rd_mem0", 96'(rd_data), 96'(sample(7)));
    check("rd_mem0_p5", 96'(rd_data[29:14]), 96'(7));
    rd_addr = 6'd5;
    #1;
    check("rd_latency_old", 96'(rd_data), 96'(sample(7)));
    tick();
    check("rd_mem5", 96'(rd_data), 96'(sample(12)));
    check("rd_mem5_p0", 96'(rd_data[7:0]), 96'(8'd12 ^ 8'hA5));
    check("rd_mem5_p7", 96'(rd_data[93:78]), 96'(16'hFFF3));
    rd_addr = 6'd63;
    tick();
    check("rd_mem63", 96'(rd_data), 96'(sample(70)));
    check("rd_mem63_p5", 96'(rd_data[29:14]), 96'(70));
    rd_addr = 6'd31;
    tick();
    check("rd_mem31", 96'(rd_data), 96'(sample(38)));

    // ---------------- re-arm from DONE ----------------
    cap_arm = 1'b1;
    tick();
    cap_arm = 1'b0;
    check("rearm_armed", 96'(cap_armed), 96'(1));
    check("rearm_done", 96'(cap_done), 96'(0));
    drive_probes(150);
    rd_addr = 6'd5;
    tick();
    tick();
    check("rearm_mem5_kept", 96'(rd_data), 96'(sample(12)));

    // trigger while reading mem[0]: old data first, new one cycle later
    rd_addr = 6'd0;
    drive_probes(200);
    cap_trigger = 1'b1;
    tick();
    cap_trigger = 1'b0;
    check("rw_same_old", 96'(rd_data), 96'(sample(7)));
    drive_probes(201);
    tick();
    check("rw_same_new", 96'(rd_data), 96'(sample(200)));
    check("cap2_armed", 96'(cap_armed), 96'(1));
    drive_probes(202);
    tick();
    drive_probes(203);
    tick();

    // ---------------- reset mid-capture ----------------
    timer_enable = 1'b1;
    reset = 1'b0;
    tick();
    check("rstcap_done", 96'(cap_done), 96'(0));
    check("rstcap_armed", 96'(cap_armed), 96'(0));
    check("rstcap_timer", 96'(timer_out), 96'(0));
    check("rstcap_rd", 96'(rd_data), 96'(0));
    reset = 1'b1;
    timer_enable = 1'b0;
    cap_trigger = 1'b1;
    rd_addr = 6'd5;
    tick();
    cap_trigger = 1'b0;
    check("idle_ignores_trig", 96'(cap_armed), 96'(0));
    check("mem_not_reset", 96'(rd_data), 96'(sample(12)));
    rd_addr = 6'd3;
    tick();
    check("cap2_mem3", 96'(rd_data), 96'(sample(203)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // absolute time bound
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
